fmap_stream_pack: RTL and testbench
===================================

# fmap_stream_pack

Streaming-to-parallel feature-map packer that sits directly upstream of the multi-channel 2× upsample stage. It accepts one DATA_WIDTH-bit feature word per handshake, assembles a complete D×H×W tile into the flat, big-endian-indexed `image` bus the upsampler consumes, and holds that bus stable under a valid/ready handshake until the downstream stage takes it. The block lets the combinational upsampler be fed from a serial memory or DMA stream.

## Interface
- `D`, default 3: channel count of the tile.
- `H`, default 2: tile height in pixels.
- `W`, default 2: tile width in pixels.
- `DATA_WIDTH`, default 16: bits per feature word.
- Derived `N = D*H*W`: words per tile. Counter width is `$clog2(N)`, minimum 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  DATA_WIDTH  incoming feature word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_last`  in  1  upstream end-of-tile marker; used only under `FMAP_PACK_LAST_CHECK_EN`.
- `image`  out  [0:N*DATA_WIDTH-1]  packed tile; word k occupies bits [k*DATA_WIDTH : k*DATA_WIDTH+DATA_WIDTH-1], so word 0 is at the MSB end.
- `image_valid`  out  1  `image` holds a complete tile.
- `image_ready`  in  1  downstream accepts the tile.
- `err_last`  out  1  sticky framing error flag.

## Operation
- Word index order is k = d*H*W + h*W + w. Stream arrival order is k = 0..N-1, which is channel-major, then row, then column.
- The state machine has two states, FILL and FULL.
- FILL:
  - `in_ready`=1 and `image_valid`=0.
  - On `in_valid && in_ready`, `in_data` is written to slot `cnt` and `cnt` is incremented.
  - Accepting slot N-1 sets `cnt` to 0 and moves the state to FULL.
- FULL:
  - `in_ready`=0 and `image_valid`=1.
  - `image` is stable.
  - On `image_ready`, the state returns to FILL.
  - There is no same-cycle bypass: a word offered in the handoff cycle is not accepted.
- Slots are never cleared between tiles. Each tile overwrites all N slots, except in the early-last case described in Configuration.
- `in_valid` may drop at any time. Gaps stall `cnt` and do not corrupt data.
- `image_ready` while in FILL is ignored.

## Timing
- Reset values:
  - state=FILL, `cnt`=0, `image`=0, `image_valid`=0, `err_last`=0.
  - `in_ready` is forced 0 while `reset` is high and rises in the first cycle after release.
- `in_ready` and `image_valid` are registered-state decodes, with no combinational path from `in_valid` or `image_ready`.
- Latency: `image_valid` rises on the clock edge that accepts word N-1, so it is visible in the cycle after that edge.
- Minimum tile period is N+1 cycles: N accepts plus one handoff cycle.
- Reset asserted mid-fill or in FULL aborts the partial or held tile.
  - `image` returns to 0 and `cnt` returns to 0.
  - The next accepted word is slot 0.

## Configuration
- `FMAP_PACK_LAST_CHECK_EN` defined:
  - `in_last` is sampled on every accepted word.
  - If `in_last`=1 on slot k<N-1: the word is stored, `err_last` is set, and the tile closes early into FULL. Slots k+1..N-1 keep their previous contents.
  - If `in_last`=0 on slot N-1: `err_last` is set and the tile still closes normally, because the count is authoritative.
  - `err_last` is sticky until `reset`.
- `FMAP_PACK_LAST_CHECK_EN` undefined:
  - `in_last` is ignored.
  - `err_last` is constant 0.
  - Tiles always close on count.

## Test plan
All scenarios use D=3, H=2, W=2, DATA_WIDTH=16, so N=12.
1. **Basic packing.** Stream 16'h0001…16'h000C with `in_valid` held high and `image_ready`=0 -> `image` = 192'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A_000B_000C. `image_valid` is 1 starting 12 cycles after the first accept, and `in_ready`=0.
2. **Backpressure.** After scenario 1, hold `image_ready`=0 for 5 cycles, then pulse it for 1 cycle -> `image` is unchanged throughout. `image_valid` falls and `in_ready` rises the cycle after the pulse.
3. **Input gaps.** Insert `in_valid`=0 for 2 cycles after every third word while streaming 16'hA000…16'hA00B -> the packed tile is exact and `image_valid` rises after the 12th accept.
4. **Mid-tile reset.** Accept 5 words, assert `reset` for 1 cycle, then stream 16'h0100…16'h010B -> `image` before the first word = 0, and the final tile is exactly 16'h0100…16'h010B.
5. **Back-to-back tiles.** Hold `image_ready`=1 and stream 24 words -> two tiles are produced. Each `image_valid` lasts 1 cycle, and the second tile completes 13 cycles after the first.
6. **Last-flag checking** (`FMAP_PACK_LAST_CHECK_EN` defined):
   - Assert `in_last` on word 8 -> FULL is entered after 9 words, `err_last`=1, and slots 9–11 hold the prior tile.
   - Repeat without the macro -> `err_last` stays 0 and the tile closes after 12 words.

Source files
------------

// File: rtl/fmap_stream_pack.sv
// fmap_stream_pack: streaming-to-parallel feature-map packer.
// Collects N = D*H*W words of DATA_WIDTH bits, one per in_valid/in_ready
// handshake, into the flat big-endian image bus (word 0 at the MSB end),
// then holds the tile under image_valid/image_ready until downstream takes it.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset; aborts any partial/held tile
//   in_data      incoming feature word
//   in_valid     in_data is valid
//   in_ready     block accepts a word this cycle (registered)
//   in_last      upstream end-of-tile marker (checked only when enabled)
//   image        packed tile, word k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   image_valid  image holds a complete tile (registered)
//   image_ready  downstream accepts the tile
//   err_last     sticky framing error flag
//
// Optional feature macro: FMAP_PACK_LAST_CHECK_EN
//   defined   -> in_last closes a tile early and framing errors set err_last
//   undefined -> in_last ignored, err_last tied to 0, tiles close on count
module fmap_stream_pack #(
  parameter int unsigned D          = 3,
  parameter int unsigned H          = 2,
  parameter int unsigned W          = 2,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_last,
  output logic [0:D*H*W*DATA_WIDTH-1]       image,
  output logic                              image_valid,
  input  logic                              image_ready,
  output logic                              err_last
);

  localparam int unsigned N  = D * H * W;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(N - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            accept_c;
  logic            at_last_c;
  logic            close_c;

  // in_ready is already 0 in FULL, so no state term is needed here
  assign accept_c  = in_valid && in_ready;
  assign at_last_c = (cnt == LAST_SLOT);

`ifdef FMAP_PACK_LAST_CHECK_EN
  // An early in_last ends the tile; the count still ends it otherwise
  assign close_c = at_last_c || in_last;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign close_c        = at_last_c;
  assign err_last       = 1'b0;
`endif

  // Control state, handshake outputs and slot storage
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      cnt         <= '0;
      image       <= '0;
      in_ready    <= 1'b0;
      image_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          in_ready    <= 1'b1;
          image_valid <= 1'b0;
          if (accept_c) begin
            for (int unsigned k = 0; k < N; k++) begin
              if (cnt == CW'(k)) begin
                image[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
              end
            end
            if (close_c) begin
              cnt         <= '0;
              state       <= FULL;
              in_ready    <= 1'b0;
              image_valid <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        FULL: begin
          // No bypass: the handoff cycle never accepts a word
          if (image_ready) begin
            state       <= FILL;
            in_ready    <= 1'b1;
            image_valid <= 1'b0;
          end
        end
        default: begin
          state       <= FILL;
          in_ready    <= 1'b0;
          image_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FMAP_PACK_LAST_CHECK_EN
  // Sticky framing error: in_last must coincide exactly with the final slot
  always_ff @(posedge clk) begin
    if (reset) begin
      err_last <= 1'b0;
    end else if (accept_c && (in_last != at_last_c)) begin
      err_last <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fmap_stream_pack.sv
// Self-checking bench for fmap_stream_pack (D=3, H=2, W=2, DATA_WIDTH=16).
module tb_fmap_stream_pack;

  localparam int unsigned N  = 12;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = N * DW;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [0:IW-1]   image;
  logic            image_valid;
  logic            image_ready;
  logic            err_last;

  fmap_stream_pack #(.D(3), .H(2), .W(2), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .image       (image),
    .image_valid (image_valid),
    .image_ready (image_ready),
    .err_last    (err_last)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [IW-1:0] exp_q[$];

  task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: each new tile pops one expectation; a held tile must not change
  logic          prev_valid = 1'b0;
  logic [IW-1:0] held;
  always @(negedge clk) begin
    if (image_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tile", IW'(1), IW'(0));
      end else begin
        check("tile_image", image, exp_q.pop_front());
      end
      held = image;
    end else if (image_valid === 1'b1 && prev_valid === 1'b1) begin
      check("hold_stable", image, held);
    end
    prev_valid = image_valid;
  end

  // Offer one word and wait (bounded) until it is accepted
  task automatic send(input logic [DW-1:0] d, input logic l);
    int t;
    t = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) check("send_timeout", IW'(0), IW'(1));
    else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_tile();
    image_ready = 1'b1;
    @(posedge clk);
    #1;
    image_ready = 1'b0;
    check("valid_after_pulse", IW'(image_valid), IW'(0));
    check("ready_after_pulse", IW'(in_ready), IW'(1));
  endtask

  typedef struct {
    logic [DW-1:0] first;
    logic [DW-1:0] step;
    int            gap_after;
    int            gap_len;
    int            hold;
    logic [IW-1:0] exp_img;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int c0;
    int t11;
    int t23;

    vecs[0] = '{16'h0001, 16'h0001, 0, 0, 5,
                192'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A_000B_000C};
    vecs[1] = '{16'hA000, 16'h0001, 3, 2, 0,
                192'hA000_A001_A002_A003_A004_A005_A006_A007_A008_A009_A00A_A00B};
    vecs[2] = '{16'h1000, 16'h0111, 5, 1, 2,
                192'h1000_1111_1222_1333_1444_1555_1666_1777_1888_1999_1AAA_1BBB};

    reset = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; image_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", IW'(in_ready), IW'(0));
    check("rst_image_valid", IW'(image_valid), IW'(0));
    check("rst_image", image, IW'(0));
    check("rst_err_last", IW'(err_last), IW'(0));
    reset = 1'b0;

    // Table-driven tiles: packing, backpressure hold, input gaps
    for (int v = 0; v < 3; v++) begin
      exp_q.push_back(vecs[v].exp_img);
      c0 = 0;
      for (int k = 0; k < N; k++) begin
        send(vecs[v].first + DW'(k) * vecs[v].step, k == N - 1);
        if (k == 0) c0 = cyc;
        if (k == N - 2) check("valid_early", IW'(image_valid), IW'(0));
        if (vecs[v].gap_after > 0 && ((k + 1) % vecs[v].gap_after) == 0 && k != N - 1) begin
          repeat (vecs[v].gap_len) @(posedge clk);
          #1;
        end
      end
      check("valid_latency", IW'(image_valid), IW'(1));
      check("in_ready_full", IW'(in_ready), IW'(0));
      if (vecs[v].gap_after == 0) check("accept_span", IW'(cyc - c0), IW'(N - 1));
      repeat (vecs[v].hold) @(posedge clk);
      #1;
      check("valid_held", IW'(image_valid), IW'(1));
      release_tile();
    end

    // Mid-tile reset aborts the partial tile
    for (int k = 0; k < 5; k++) send(16'h0055 + DW'(k), 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_image", image, IW'(0));
    check("midrst_valid", IW'(image_valid), IW'(0));
    check("midrst_in_ready", IW'(in_ready), IW'(0));
    exp_q.push_back(192'h0100_0101_0102_0103_0104_0105_0106_0107_0108_0109_010A_010B);
    for (int k = 0; k < N; k++) begin
      send(16'h0100 + DW'(k), k == N - 1);
      if (k == 0) check("midrst_first_image", image[0 +: DW], IW'(16'h0100));
    end
    check("midrst_tile_valid", IW'(image_valid), IW'(1));
    release_tile();

    // Back-to-back tiles with image_ready held high
    image_ready = 1'b1;
    exp_q.push_back(192'h0200_0201_0202_0203_0204_0205_0206_0207_0208_0209_020A_020B);
    exp_q.push_back(192'h0300_0301_0302_0303_0304_0305_0306_0307_0308_0309_030A_030B);
    t11 = 0;
    t23 = 0;
    for (int k = 0; k < 2 * N; k++) begin
      send((k < N) ? 16'h0200 + DW'(k) : 16'h0300 + DW'(k - N), (k % N) == N - 1);
      if (k == N - 1) begin
        t11 = cyc;
        check("b2b_valid1", IW'(image_valid), IW'(1));
      end
      if (k == N) check("b2b_valid1_gone", IW'(image_valid), IW'(0));
    end
    t23 = cyc;
    check("b2b_valid2", IW'(image_valid), IW'(1));
    check("b2b_period", IW'(t23 - t11), IW'(N + 1));
    @(posedge clk);
    #1;
    check("b2b_valid2_gone", IW'(image_valid), IW'(0));
    image_ready = 1'b0;
    check("err_clean", IW'(err_last), IW'(0));

    // in_last asserted on word 8
`ifdef FMAP_PACK_LAST_CHECK_EN
    exp_q.push_back(192'h0400_0401_0402_0403_0404_0405_0406_0407_0408_0309_030A_030B);
    for (int k = 0; k < 9; k++) send(16'h0400 + DW'(k), k == 8);
    check("early_last_valid", IW'(image_valid), IW'(1));
    check("early_last_err", IW'(err_last), IW'(1));
    release_tile();
    check("err_sticky", IW'(err_last), IW'(1));
`else
    exp_q.push_back(192'h0400_0401_0402_0403_0404_0405_0406_0407_0408_0409_040A_040B);
    for (int k = 0; k < N; k++) begin
      send(16'h0400 + DW'(k), k == 8);
      if (k == 8) begin
        check("last_ignored_valid", IW'(image_valid), IW'(0));
        check("last_ignored_err", IW'(err_last), IW'(0));
      end
    end
    check("count_close_valid", IW'(image_valid), IW'(1));
    check("count_close_err", IW'(err_last), IW'(0));
    release_tile();
`endif

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", IW'(exp_q.size()), IW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
